mac_job_sequencer: RTL and testbench

// - Sequences the CFU 8-lane SIMD MAC datapath (input-stationary buffer + accumulator) without per-step CPU commands.
// - Takes one job (buffer base, dot-product length, output count) and consumes a 64-bit filter stream, one word-pair per step.
// - Issues clear/step/index to the MAC, collects each finished accumulator and returns it on a result handshake.
// - Sits between the CFU command decoder and the MAC/buffer datapath.

---
 rtl/mac_job_sequencer_pkg.sv | 17 +
 rtl/mac_job_sequencer_if.sv | 48 ++++
 rtl/mac_job_sequencer.sv | 122 ++++++++++++
 tb/tb_mac_job_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_job_sequencer_pkg.sv
// Shared types and default sizes for the CFU MAC job sequencer.
// Imported by the interface and the sequencer itself.
package mac_job_sequencer_pkg;

    localparam int IDX_W_DEF     = 8;
    localparam int BUF_DEPTH_DEF = 164;
    localparam int NOUT_W_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        WAIT,
        EMIT
    } state_e;

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Bundle of job, filter-stream, MAC and result signals around the sequencer.
// slave = sequencer view, master = decoder/datapath view.
interface mac_job_sequencer_if
    import mac_job_sequencer_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int NOUT_W = NOUT_W_DEF
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_base;
    logic [IDX_W-1:0]  cfg_len;
    logic [NOUT_W-1:0] cfg_nout;
    logic              abort;
    logic              flt_valid;
    logic              flt_ready;
    logic [63:0]       flt_data;
    logic              mac_clr;
    logic              mac_step;
    logic [IDX_W-1:0]  mac_idx;
    logic [31:0]       mac_w0;
    logic [31:0]       mac_w1;
    logic [31:0]       mac_acc;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;
    logic              res_last;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  cfg_valid, cfg_base, cfg_len, cfg_nout, abort,
        input  flt_valid, flt_data, mac_acc, res_ready,
        output cfg_ready, flt_ready, mac_clr, mac_step, mac_idx,
        output mac_w0, mac_w1, res_valid, res_data, res_last,
        output busy, done, err
    );

    modport master (
        output cfg_valid, cfg_base, cfg_len, cfg_nout, abort,
        output flt_valid, flt_data, mac_acc, res_ready,
        input  cfg_ready, flt_ready, mac_clr, mac_step, mac_idx,
        input  mac_w0, mac_w1, res_valid, res_data, res_last,
        input  busy, done, err
    );

endinterface

// File: rtl/mac_job_sequencer.sv
// Runs one MAC job: clear, len steps over the filter stream, capture, emit.
// Repeats per output; done/err are single-cycle pulses.
module mac_job_sequencer
    import mac_job_sequencer_pkg::*;
#(
    parameter int IDX_W     = IDX_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int NOUT_W    = NOUT_W_DEF
) (
    input logic                clk,
    input logic                reset,
    mac_job_sequencer_if.slave bus
);

    localparam logic [IDX_W+1:0] DEPTH_W = (IDX_W+2)'(BUF_DEPTH);

    state_e            state_q;
    logic [IDX_W-1:0]  base_q, len_q, idx_q, pair_q;
    logic [IDX_W-1:0]  idx_d, pair_d;
    logic [NOUT_W-1:0] nout_q, out_cnt_q, out_cnt_d;
    logic [31:0]       res_data_q;
    logic              done_q, err_q;

    logic              run, emit, accept;
    logic              last_pair, last_out;
    logic              zero_job, over;
    logic [IDX_W+1:0]  end_sum;

    assign run    = (state_q == RUN);
    assign emit   = (state_q == EMIT);
    assign accept = bus.cfg_valid && bus.cfg_ready;

    assign idx_d     = idx_q + IDX_W'(2);
    assign pair_d    = pair_q + IDX_W'(1);
    assign out_cnt_d = out_cnt_q + NOUT_W'(1);
    assign last_pair = (pair_q == len_q - IDX_W'(1));
    assign last_out  = (out_cnt_q == nout_q - NOUT_W'(1));

    // Range check in two extra bits so base + 2*len cannot wrap
    assign end_sum  = {2'b00, bus.cfg_base} + {1'b0, bus.cfg_len, 1'b0};
    assign over     = (end_sum > DEPTH_W);
    assign zero_job = (bus.cfg_len == '0) || (bus.cfg_nout == '0);

    assign bus.cfg_ready = (state_q == IDLE) && !bus.abort;
    assign bus.flt_ready = run;
    assign bus.mac_step  = run && bus.flt_valid;
    assign bus.mac_idx   = run ? idx_q : '0;
    assign bus.mac_w0    = run ? bus.flt_data[31:0] : '0;
    assign bus.mac_w1    = run ? bus.flt_data[63:32] : '0;
    assign bus.mac_clr   = (state_q == CLEAR);
    assign bus.res_valid = emit;
    assign bus.res_last  = emit && last_out;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            nout_q     <= '0;
            idx_q      <= '0;
            pair_q     <= '0;
            out_cnt_q  <= '0;
            res_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.abort && state_q != IDLE) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            base_q    <= bus.cfg_base;
                            len_q     <= bus.cfg_len;
                            nout_q    <= bus.cfg_nout;
                            out_cnt_q <= '0;
                            if (zero_job)  done_q  <= 1'b1;
                            else if (over) err_q   <= 1'b1;
                            else           state_q <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        idx_q   <= base_q;
                        pair_q  <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        if (bus.flt_valid) begin
                            idx_q  <= idx_d;
                            pair_q <= pair_d;
                            if (last_pair) state_q <= WAIT;
                        end
                    end
                    // Accumulator reflects the final step one cycle later
                    WAIT: begin
                        res_data_q <= bus.mac_acc;
                        state_q    <= EMIT;
                    end
                    EMIT: begin
                        if (bus.res_ready) begin
                            if (last_out) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                out_cnt_q <= out_cnt_d;
                                state_q   <= CLEAR;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer: job table plus abort/reset/back-to-back.
// The bench models the MAC accumulator and the filter stream.
module tb_mac_job_sequencer;
    import mac_job_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_job_sequencer_if #(.IDX_W(8), .NOUT_W(16)) bus ();

    mac_job_sequencer #(.IDX_W(8), .BUF_DEPTH(164), .NOUT_W(16)) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stimulus environment
    logic        fv_en = 1'b0;
    logic        gaps = 1'b0;
    int          rdelay = 0;
    int          rv_wait = 0;
    int          cyc = 0;
    int          fk = 0;
    logic        fk_clr = 1'b0;
    logic [31:0] acc = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fk_clr) fk <= 0;
        else if (bus.flt_valid && bus.flt_ready) fk <= fk + 1;
        if (bus.mac_clr) acc <= '0;
        else if (bus.mac_step) acc <= acc + bus.mac_w0 + bus.mac_w1;
        if (bus.res_valid && !bus.res_ready) rv_wait <= rv_wait + 1;
        else rv_wait <= 0;
    end

    assign bus.flt_valid = fv_en && (!gaps || (cyc % 4 == 0));
    assign bus.flt_data  = {32'(20 * fk + 20), 32'(20 * fk + 10)};
    assign bus.mac_acc   = acc;
    assign bus.res_ready = (rv_wait >= rdelay);

    // Monitor, sampled on the falling edge
    logic        mon_clr = 1'b0;
    int          n_step, n_clr, n_done, n_err, n_rv, unstable, first_rv, done_cyc;
    int          sidx[$];
    int          clr_cyc[$];
    logic [31:0] rd_q[$];
    logic        last_q[$];
    logic        pend;
    logic [31:0] prev_d;

    always @(negedge clk) begin
        if (mon_clr) begin
            n_step = 0; n_clr = 0; n_done = 0; n_err = 0; n_rv = 0;
            unstable = 0; first_rv = -1; done_cyc = -1;
            sidx.delete(); clr_cyc.delete(); rd_q.delete(); last_q.delete();
            pend = 1'b0;
        end else if (rst_n) begin
            if (bus.mac_step) begin
                n_step++;
                sidx.push_back(int'(bus.mac_idx));
            end
            if (bus.mac_clr) begin
                n_clr++;
                clr_cyc.push_back(cyc);
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.err) n_err++;
            if (bus.res_valid) begin
                n_rv++;
                if (first_rv < 0) first_rv = cyc;
                if (pend && bus.res_data !== prev_d) unstable++;
                if (bus.res_ready) begin
                    rd_q.push_back(bus.res_data);
                    last_q.push_back(bus.res_last);
                end
            end
            pend = bus.res_valid && !bus.res_ready;
            prev_d = bus.res_data;
        end
    end

    // Filter pair k carries w0 = 20k+10, w1 = 20k+20
    function automatic logic [31:0] exp_sum(input int o, input int len);
        logic [31:0] s = '0;
        for (int j = 0; j < len; j++) s += 32'(40 * (o * len + j) + 30);
        return s;
    endfunction

    task automatic prep();
        fk_clr = 1'b1;
        mon_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        fk_clr = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic start_job(input int b, input int l, input int n);
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b1;
        bus.cfg_base  = 8'(b);
        bus.cfg_len   = 8'(l);
        bus.cfg_nout  = 16'(n);
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int t = 0;
        while (n_done + n_err == 0 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 3000) chk({name, "_timeout"}, 1, 0);
        repeat (4) @(negedge clk);
        #1;
    endtask

    typedef struct {
        int base, len, nout;
        bit gaps;
        int rd;
        int steps, clrs, nres, done, err;
    } vec_t;

    vec_t vt[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0,   2,  1, 0, 0, 2,  1, 1, 1, 0};
        vt[1] = '{4,   3,  2, 0, 0, 6,  2, 2, 1, 0};
        vt[2] = '{2,   3,  2, 1, 5, 6,  2, 2, 1, 0};
        vt[3] = '{0,   0,  3, 0, 0, 0,  0, 0, 1, 0};
        vt[4] = '{160, 4,  1, 0, 0, 0,  0, 0, 0, 1};
        vt[5] = '{156, 4,  1, 0, 0, 4,  1, 1, 1, 0};
        vt[6] = '{0,   2,  0, 0, 0, 0,  0, 0, 1, 0};
        vt[7] = '{0,   82, 1, 0, 0, 82, 1, 1, 1, 0};
        vt[8] = '{2,   82, 1, 0, 0, 0,  0, 0, 0, 1};
        vt[9] = '{255, 255,1, 0, 0, 0,  0, 0, 0, 1};

        bus.cfg_valid = 1'b0;
        bus.cfg_base  = '0;
        bus.cfg_len   = '0;
        bus.cfg_nout  = '0;
        bus.abort     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_mac_clr", bus.mac_clr, 0);
        chk("rst_flt_ready", bus.flt_ready, 0);
        chk("rst_done_err", {bus.done, bus.err}, 0);
        rst_n = 1'b1;
        fv_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            gaps = vt[i].gaps;
            rdelay = vt[i].rd;
            prep();
            start_job(vt[i].base, vt[i].len, vt[i].nout);
            wait_end($sformatf("v%0d", i));
            chk($sformatf("v%0d_steps", i), n_step, vt[i].steps);
            chk($sformatf("v%0d_clrs", i), n_clr, vt[i].clrs);
            chk($sformatf("v%0d_nres", i), rd_q.size(), vt[i].nres);
            chk($sformatf("v%0d_done", i), n_done, vt[i].done);
            chk($sformatf("v%0d_err", i), n_err, vt[i].err);
            chk($sformatf("v%0d_stable", i), unstable, 0);
            for (int j = 0; j < rd_q.size(); j++) begin
                chk($sformatf("v%0d_data%0d", i, j), rd_q[j], exp_sum(j, vt[i].len));
                chk($sformatf("v%0d_last%0d", i, j), last_q[j], (j == rd_q.size() - 1));
            end
            for (int s = 0; s < sidx.size(); s++)
                chk($sformatf("v%0d_idx%0d", i, s), sidx[s], vt[i].base + 2 * (s % vt[i].len));
            if (!vt[i].gaps && vt[i].nres > 0 && clr_cyc.size() > 0)
                chk($sformatf("v%0d_latency", i), first_rv - clr_cyc[0], vt[i].len + 2);
        end
        gaps = 1'b0;
        rdelay = 0;

        // Abort right after the first step
        begin
            int t = 0;
            prep();
            start_job(0, 3, 1);
            while (n_step == 0 && t < 50) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk("abort_reach_step", n_step, 1);
            bus.abort = 1'b1;
            @(posedge clk);
            #1;
            bus.abort = 1'b0;
            @(negedge clk);
            chk("abort_busy", bus.busy, 0);
            chk("abort_cfg_ready", bus.cfg_ready, 1);
            repeat (10) @(negedge clk);
            #1;
            chk("abort_steps", n_step, 1);
            chk("abort_no_res", n_rv, 0);
            chk("abort_no_done", n_done, 0);
        end

        // Asynchronous reset while a result is waiting
        begin
            int t = 0;
            prep();
            rdelay = 1000;
            start_job(0, 2, 1);
            while (!bus.res_valid && t < 50) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk("rstemit_res_valid", bus.res_valid, 1);
            chk("rstemit_data", bus.res_data, 100);
            rst_n = 1'b0;
            #1;
            chk("rstemit_drop", bus.res_valid, 0);
            chk("rstemit_busy", bus.busy, 0);
            chk("rstemit_cleared", bus.res_data, 0);
            @(negedge clk);
            rst_n = 1'b1;
            rdelay = 0;
        end

        // cfg_valid held through the last handshake
        begin
            int t = 0;
            prep();
            @(posedge clk);
            #1;
            bus.cfg_base  = 8'd0;
            bus.cfg_len   = 8'd1;
            bus.cfg_nout  = 16'd1;
            bus.cfg_valid = 1'b1;
            while (clr_cyc.size() < 2 && t < 100) begin
                @(negedge clk);
                #1;
                t++;
            end
            bus.cfg_valid = 1'b0;
            chk("b2b_two_clears", clr_cyc.size(), 2);
            chk("b2b_done_first", n_done, 1);
            if (clr_cyc.size() >= 2)
                chk("b2b_clr_after_done", clr_cyc[1] - done_cyc, 1);
            t = 0;
            while (n_done < 2 && t < 100) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk("b2b_done_second", n_done, 2);
            chk("b2b_nres", rd_q.size(), 2);
            if (rd_q.size() == 2) begin
                chk("b2b_data0", rd_q[0], 30);
                chk("b2b_data1", rd_q[1], 70);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
